can_wb_master: RTL and testbench

CAN_WB_MASTER -- requirements
Module: can_wb_master

---
 rtl/can_wb_pkg.sv | 18 +
 rtl/can_wb_master.sv | 154 +++++++++++++++
 tb/tb_can_wb_master.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/can_wb_pkg.sv
// Shared definitions for the command-to-Wishbone bridge.
// Holds the bridge FSM state encoding and the default parameter values
// used by can_wb_master.
package can_wb_pkg;

    // Bridge FSM states: waiting for a command, running the bus cycle,
    // holding a response for the consumer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_ADR_W          = 8;
    localparam int unsigned DEF_DAT_W          = 8;

endpackage : can_wb_pkg

// File: rtl/can_wb_master.sv
// Command/response to Wishbone classic initiator bridge.
//
// One accepted command produces exactly one Wishbone transfer. The transfer
// ends on wb_ack_i or after TIMEOUT_CYCLES bus cycles without ack. Its result
// is then held on the response port until consumed.
//
// Ports:
//   wb_clk_i, wb_rst_ni             clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o       command handshake (ready only in IDLE)
//   cmd_we_i, cmd_adr_i, cmd_dat_i  command payload
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_dat_o, rsp_err_o            read data (0 for writes/errors), timeout flag
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_dat_o              Wishbone initiator outputs (registered)
//   wb_dat_i, wb_ack_i              Wishbone slave return path
module can_wb_master
    import can_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned ADR_W          = DEF_ADR_W,
    parameter int unsigned DAT_W          = DEF_DAT_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen during the last BUS cycle allowed before abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    // Ready is the only combinational output; forced low while in reset.
    assign cmd_ready_o = wb_rst_ni && (state_q == IDLE);

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

    // Next-state and next-output logic for the bridge FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    we_d      = cmd_we_i;
                    adr_d     = cmd_adr_i;
                    dat_d     = cmd_dat_i;
                    cnt_d     = {CNT_W{1'b0}};
                    cyc_d     = 1'b1;
                    rsp_dat_d = {DAT_W{1'b0}};
                    rsp_err_d = 1'b0;
                    state_d   = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Ack is checked first so it wins over a coinciding timeout.
                if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? {DAT_W{1'b0}} : wb_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = {DAT_W{1'b0}};
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= {ADR_W{1'b0}};
            dat_q       <= {DAT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DAT_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule : can_wb_master

// File: tb/tb_can_wb_master.sv
// Self-checking bench for can_wb_master with a short timeout (4 bus cycles).
module tb_can_wb_master;

    localparam int T = 4;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [7:0] cmd_adr, cmd_dat;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_dat;
    logic       wb_cyc, wb_stb, wb_we, wb_ack;
    logic [7:0] wb_adr, wb_dat_o, wb_dat_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        int         wait_n;   // wait cycles before ack; >= T means never acks in time
        logic [7:0] rdata;
        int         hold;     // cycles rsp_ready_i stays low in RESP
        int         exp_cycles;
        logic       exp_err;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    can_wb_master #(
        .TIMEOUT_CYCLES(T),
        .ADR_W(8),
        .DAT_W(8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: one transfer, ack after wait_n wait states unless
    // T cycles pass first; reads return slave data, writes/errors return 0.
    task automatic model(input logic we, input int wait_n, input logic [7:0] rdata,
                         output int cycles, output logic err, output logic [7:0] dat);
        err    = (wait_n >= T);
        cycles = err ? T : wait_n + 1;
        dat    = (!we && !err) ? rdata : 8'h00;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int cycles;
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = 8'($urandom);
        cmd_dat   = 8'($urandom);
        cycles    = 0;
        while (wb_cyc === 1'b1 && cycles < 64) begin
            chk({tag, "_stb"},      32'(wb_stb),    32'd1);
            chk({tag, "_we"},       32'(wb_we),     32'(v.we));
            chk({tag, "_adr"},      32'(wb_adr),    32'(v.adr));
            chk({tag, "_wdat"},     32'(wb_dat_o),  32'(v.dat));
            chk({tag, "_rsp_busy"}, 32'(rsp_valid), 32'd0);
            chk({tag, "_rdy_busy"}, 32'(cmd_ready), 32'd0);
            wb_ack   = (cycles == v.wait_n);
            wb_dat_i = wb_ack ? v.rdata : 8'($urandom);
            step();
            wb_ack = 1'b0;
            cycles++;
        end
        chk({tag, "_bus_cycles"}, 32'(cycles),    32'(v.exp_cycles));
        chk({tag, "_stb_end"},    32'(wb_stb),    32'd0);
        chk({tag, "_rsp_valid"},  32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_dat"},    32'(rsp_dat),   32'(v.exp_dat));
        chk({tag, "_rsp_err"},    32'(rsp_err),   32'(v.exp_err));
        // Hold response: stray acks and new commands must change nothing.
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            wb_ack    = 1'($urandom);
            wb_dat_i  = 8'($urandom);
            step();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_dat"},   32'(rsp_dat),   32'(v.exp_dat));
            chk({tag, "_hold_err"},   32'(rsp_err),   32'(v.exp_err));
            chk({tag, "_hold_rdy"},   32'(cmd_ready), 32'd0);
            chk({tag, "_hold_cyc"},   32'(wb_cyc),    32'd0);
        end
        cmd_valid = 1'b0;
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_post_cyc"},   32'(wb_cyc),    32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cyc"},   32'(wb_cyc),    32'd0);
        chk({tag, "_stb"},   32'(wb_stb),    32'd0);
        chk({tag, "_we"},    32'(wb_we),     32'd0);
        chk({tag, "_adr"},   32'(wb_adr),    32'd0);
        chk({tag, "_wdat"},  32'(wb_dat_o),  32'd0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdat"},  32'(rsp_dat),   32'd0);
        chk({tag, "_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        // Directed vectors with hand-derived expectations (T = 4).
        vecs[0] = '{1'b1, 8'h05, 8'hA3, 0,  8'hFF, 0,  1, 1'b0, 8'h00}; // zero-wait write
        vecs[1] = '{1'b0, 8'h02, 8'h00, 3,  8'h5C, 0,  4, 1'b0, 8'h5C}; // read, 3 waits
        vecs[2] = '{1'b0, 8'h11, 8'h00, 99, 8'h99, 3,  4, 1'b1, 8'h00}; // read timeout
        vecs[3] = '{1'b0, 8'h33, 8'h00, 3,  8'h77, 0,  4, 1'b0, 8'h77}; // ack on last cycle
        vecs[4] = '{1'b0, 8'h44, 8'h00, 0,  8'hC3, 10, 1, 1'b0, 8'hC3}; // long rsp hold
        vecs[5] = '{1'b1, 8'hFE, 8'h5A, 99, 8'h12, 1,  4, 1'b1, 8'h00}; // write timeout
        vecs[6] = '{1'b0, 8'h80, 8'h00, 2,  8'h00, 2,  3, 1'b0, 8'h00}; // read zero data

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 8'h00; cmd_dat = 8'h00;
        rsp_ready = 1'b0; wb_ack = 1'b0; wb_dat_i = 8'h00;
        step();
        step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while the bus cycle is open.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 8'h3C; cmd_dat = 8'hE1;
        step();
        cmd_valid = 1'b0;
        chk("rstbus_cyc_open", 32'(wb_cyc), 32'd1);
        rst_n = 1'b0;
        step();
        chk_reset_vals("rstbus");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstbus_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rstbus_idle", 32'(cmd_ready), 32'd1);
        end
        run_txn(vecs[1], "after_rstbus");

        // Reset while a response is pending.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h09;
        step();
        cmd_valid = 1'b0;
        wb_ack = 1'b1; wb_dat_i = 8'h6B;
        step();
        wb_ack = 1'b0;
        chk("rstresp_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk_reset_vals("rstresp");
        rst_n = 1'b1;
        step();
        chk("rstresp_no_rsp", 32'(rsp_valid), 32'd0);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            v.we     = 1'($urandom);
            v.adr    = 8'($urandom);
            v.dat    = 8'($urandom);
            v.wait_n = $urandom_range(0, 6);
            v.rdata  = 8'($urandom);
            v.hold   = $urandom_range(0, 3);
            model(v.we, v.wait_n, v.rdata, v.exp_cycles, v.exp_err, v.exp_dat);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_can_wb_master
